// File: rtl/ram_block_streamer.sv
// rtl/ram_block_streamer.sv - RAM block read-out into an AXI-Stream packet
module ram_block_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  axi_aclk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_LEN = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_done;
    logic                  w_done_next;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issue_idx;
    logic                  r_inflight;
    logic                  r_inflight_last;

    // FIFO entries carry {last, data}
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_empty;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_occ;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [ADDR_WIDTH:0]   w_len_clamped;

    assign w_empty       = (r_count == '0);
    assign w_head        = r_mem[r_rptr];
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !w_empty && w_head[DATA_WIDTH];
    assign w_pop         = m_axis_tvalid && m_axis_tready;
    assign w_push        = r_inflight;

    // Counting the read in flight keeps the FIFO from ever overflowing
    assign w_occ         = r_count + CW'(r_inflight);
    assign w_issue       = (r_state == S_RUN) && (r_issue_idx != r_len)
                           && (w_occ < CW'(FIFO_DEPTH));
    assign w_issue_last  = (r_issue_idx == (r_len - ONE_LEN));
    assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    assign ram_rd_en     = w_issue;
    assign ram_rd_addr   = r_base + r_issue_idx[ADDR_WIDTH-1:0];
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            w_done_next = 1'b1;
                        end else begin
                            w_load       = 1'b1;
                            w_state_next = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue && w_issue_last) begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head[DATA_WIDTH]) begin
                        w_state_next = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!resetn) begin
            r_base      <= '0;
            r_len       <= '0;
            r_issue_idx <= '0;
        end else if (w_load) begin
            r_base      <= base_addr;
            r_len       <= w_len_clamped;
            r_issue_idx <= '0;
        end else if (w_issue) begin
            r_issue_idx <= r_issue_idx + ONE_LEN;
        end
    end

    // Abort discards the outstanding read and everything buffered
    always_ff @(posedge axi_aclk) begin
        if (!resetn || abort) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_inflight_last, ram_rd_data};
        end
    end

endmodule

// File: tb/tb_ram_block_streamer.sv
// tb/tb_ram_block_streamer.sv - directed bench for ram_block_streamer
module tb_ram_block_streamer;

    logic        axi_aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  length = '0;
    logic        busy;
    logic        done;
    logic        ram_rd_en;
    logic [7:0]  ram_rd_addr;
    logic [31:0] ram_rd_data = '0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;

    ram_block_streamer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .axi_aclk(axi_aclk), .resetn(resetn), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 axi_aclk = ~axi_aclk;

    logic [31:0] ram [256];
    always @(posedge axi_aclk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    logic [7:0]  q_addr[$];
    int          n_done, done_cyc, viol, rd_win, first_rd;

    task automatic launch(input logic [7:0] b, input logic [8:0] l);
        @(negedge axi_aclk);
        base_addr = b;
        length    = l;
        start     = 1'b1;
    endtask

    // Runs a transfer already launched; tready low in cycles lo..hi, a stray start at ign_cyc
    task automatic collect(input int budget, input int lo, input int hi,
                           input int extra, input int ign_cyc);
        bit          prev_stall;
        logic [31:0] prev_d;
        bit          prev_l;
        q_data.delete(); q_last.delete(); q_addr.delete();
        n_done = 0; done_cyc = -1; viol = 0; rd_win = 0; first_rd = -1;
        prev_stall = 0; prev_d = '0; prev_l = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge axi_aclk);
            if (c == ign_cyc) begin
                start = 1'b1; base_addr = 8'h40; length = 9'd2;
            end else begin
                start = 1'b0;
            end
            m_axis_tready = !(c >= lo && c <= hi);
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l))
                viol++;
            if (ram_rd_en) begin
                q_addr.push_back(ram_rd_addr);
                if (first_rd < 0) first_rd = c;
                if (c <= hi) rd_win++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_last.push_back(m_axis_tlast);
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (done_cyc >= 0 && c >= done_cyc + extra) break;
        end
        start = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge axi_aclk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got %b exp 0", done); end
        n_vec++; if (ram_rd_en !== 1'b0) begin n_err++; $display("FAIL reset rd_en got %b exp 0", ram_rd_en); end
        n_vec++; if (ram_rd_addr !== 8'h00) begin n_err++; $display("FAIL reset rd_addr got %h exp 00", ram_rd_addr); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset tvalid got %b exp 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset tlast got %b exp 0", m_axis_tlast); end
        n_vec++; if (m_axis_tdata !== 32'h0) begin n_err++; $display("FAIL reset tdata got %h exp 0", m_axis_tdata); end
        resetn = 1'b1;
        @(negedge axi_aclk);
    endtask

    task automatic test_basic_len4;
        launch(8'h00, 9'd4);
        for (int c = 1; c <= 9; c++) begin
            @(negedge axi_aclk);
            start = 1'b0;
            n_vec++;
            if (ram_rd_en !== (c <= 4)) begin n_err++; $display("FAIL basic rd_en cyc%0d got %b exp %b", c, ram_rd_en, (c <= 4)); end
            if (c <= 4) begin
                n_vec++;
                if (ram_rd_addr !== 8'(c - 1)) begin n_err++; $display("FAIL basic rd_addr cyc%0d got %h exp %h", c, ram_rd_addr, 8'(c - 1)); end
            end
            n_vec++;
            if (m_axis_tvalid !== (c >= 3 && c <= 6)) begin n_err++; $display("FAIL basic tvalid cyc%0d got %b exp %b", c, m_axis_tvalid, (c >= 3 && c <= 6)); end
            if (c >= 3 && c <= 6) begin
                n_vec++;
                if (m_axis_tdata !== 32'h100 + 32'(c - 3)) begin n_err++; $display("FAIL basic tdata cyc%0d got %h exp %h", c, m_axis_tdata, 32'h100 + 32'(c - 3)); end
                n_vec++;
                if (m_axis_tlast !== (c == 6)) begin n_err++; $display("FAIL basic tlast cyc%0d got %b exp %b", c, m_axis_tlast, (c == 6)); end
            end
            n_vec++;
            if (done !== (c == 7)) begin n_err++; $display("FAIL basic done cyc%0d got %b exp %b", c, done, (c == 7)); end
            n_vec++;
            if (busy !== (c <= 6)) begin n_err++; $display("FAIL basic busy cyc%0d got %b exp %b", c, busy, (c <= 6)); end
        end
    endtask

    task automatic test_backpressure;
        launch(8'h00, 9'd8);
        collect(100, 3, 12, 3, -1);
        n_vec++; if (rd_win !== 4) begin n_err++; $display("FAIL bp reads_while_stalled got %0d exp 4", rd_win); end
        n_vec++; if (viol !== 0) begin n_err++; $display("FAIL bp stability_violations got %0d exp 0", viol); end
        n_vec++; if (q_data.size() !== 8) begin n_err++; $display("FAIL bp beats got %0d exp 8", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 8; i++) begin
            n_vec++;
            if (q_data[i] !== 32'h100 + 32'(i) || q_last[i] !== (i == 7)) begin
                n_err++; $display("FAIL bp beat%0d got %h/%b exp %h/%b", i, q_data[i], q_last[i], 32'h100 + 32'(i), (i == 7));
            end
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL bp done_pulses got %0d exp 1", n_done); end
    endtask

    task automatic test_wrap;
        logic [7:0] ea;
        launch(8'hFE, 9'd4);
        collect(50, 0, -1, 2, -1);
        n_vec++; if (q_addr.size() !== 4) begin n_err++; $display("FAIL wrap reads got %0d exp 4", q_addr.size()); end
        n_vec++; if (q_data.size() !== 4) begin n_err++; $display("FAIL wrap beats got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_addr.size() && i < q_data.size(); i++) begin
            ea = 8'hFE + 8'(i);
            n_vec++;
            if (q_addr[i] !== ea) begin n_err++; $display("FAIL wrap addr%0d got %h exp %h", i, q_addr[i], ea); end
            n_vec++;
            if (q_data[i] !== 32'h100 + 32'(ea) || q_last[i] !== (i == 3)) begin
                n_err++; $display("FAIL wrap beat%0d got %h/%b exp %h/%b", i, q_data[i], q_last[i], 32'h100 + 32'(ea), (i == 3));
            end
        end
    endtask

    task automatic test_zero_len;
        launch(8'h10, 9'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge axi_aclk);
            start = 1'b0;
            n_vec++;
            if (done !== (c == 1) || busy !== 1'b0 || ram_rd_en !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                n_err++; $display("FAIL zero_len cyc%0d got done=%b busy=%b rd=%b tv=%b exp done=%b busy=0 rd=0 tv=0",
                                  c, done, busy, ram_rd_en, m_axis_tvalid, (c == 1));
            end
        end
    endtask

    task automatic test_clamp;
        int bad;
        launch(8'h00, 9'd300);
        collect(400, 0, -1, 2, -1);
        n_vec++; if (q_data.size() !== 256) begin n_err++; $display("FAIL clamp beats got %0d exp 256", q_data.size()); end
        bad = 0;
        for (int i = 0; i < q_data.size() && i < 256; i++)
            if (q_data[i] !== 32'h100 + 32'(i) || q_last[i] !== (i == 255)) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL clamp data_errors got %0d exp 0", bad); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL clamp done_pulses got %0d exp 1", n_done); end
    endtask

    task automatic test_abort(input bit use_reset);
        int hs, stray;
        hs = 0; stray = 0;
        launch(8'h00, 9'd8);
        for (int c = 1; c <= 5; c++) begin
            @(negedge axi_aclk);
            start = 1'b0;
            if (c == 5) begin
                m_axis_tready = 1'b0;
                if (use_reset) resetn = 1'b0; else abort = 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready) hs++;
        end
        @(negedge axi_aclk);
        abort = 1'b0; resetn = 1'b1; m_axis_tready = 1'b1;
        n_vec++; if (hs !== 2) begin n_err++; $display("FAIL abort%0d beats_before got %0d exp 2", use_reset, hs); end
        n_vec++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL abort%0d after got tv=%b busy=%b done=%b exp 0/0/0", use_reset, m_axis_tvalid, busy, done);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge axi_aclk);
            if (m_axis_tvalid || done || busy || ram_rd_en) stray++;
        end
        n_vec++; if (stray !== 0) begin n_err++; $display("FAIL abort%0d stray_activity got %0d exp 0", use_reset, stray); end
        launch(8'h10, 9'd4);
        collect(50, 0, -1, 2, -1);
        n_vec++; if (q_data.size() !== 4) begin n_err++; $display("FAIL abort%0d restart_beats got %0d exp 4", use_reset, q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_vec++;
            if (q_data[i] !== 32'h110 + 32'(i) || q_last[i] !== (i == 3)) begin
                n_err++; $display("FAIL abort%0d restart_beat%0d got %h/%b exp %h/%b", use_reset, i, q_data[i], q_last[i], 32'h110 + 32'(i), (i == 3));
            end
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL abort%0d restart_done got %0d exp 1", use_reset, n_done); end
    endtask

    task automatic test_start_while_busy;
        launch(8'h00, 9'd4);
        collect(50, 0, -1, 6, 2);
        n_vec++; if (q_data.size() !== 4) begin n_err++; $display("FAIL busy_start beats got %0d exp 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_vec++;
            if (q_data[i] !== 32'h100 + 32'(i) || q_last[i] !== (i == 3)) begin
                n_err++; $display("FAIL busy_start beat%0d got %h/%b exp %h/%b", i, q_data[i], q_last[i], 32'h100 + 32'(i), (i == 3));
            end
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL busy_start done_pulses got %0d exp 1", n_done); end
        n_vec++; if (q_addr.size() !== 4) begin n_err++; $display("FAIL busy_start reads got %0d exp 4", q_addr.size()); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        seen = 0;
        launch(8'h00, 9'd2);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge axi_aclk);
            start = 1'b0;
            if (done) seen = 1;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b first_done got %b exp 1", seen); end
        base_addr = 8'h20; length = 9'd2; start = 1'b1;
        collect(30, 0, -1, 2, -1);
        n_vec++; if (first_rd !== 1) begin n_err++; $display("FAIL b2b first_rd_cycle got %0d exp 1", first_rd); end
        n_vec++;
        if (q_data.size() !== 2 || q_data[0] !== 32'h120 || q_data[1] !== 32'h121 || q_last[1] !== 1'b1) begin
            n_err++; $display("FAIL b2b beats got n=%0d exp 2 words 120,121 with tlast on 121", q_data.size());
        end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL b2b done_pulses got %0d exp 1", n_done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h100 + 32'(i);
        test_reset();
        test_basic_len4();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_clamp();
        test_abort(1'b0);
        test_abort(1'b1);
        test_start_while_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
